// File: rtl/ggt_arbiter.sv
// Round-robin arbiter that shares one ggt_top GCD engine among N_REQ requesters.
// Zero operands are answered directly; a hung engine is timed out and reset.
module ggt_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n_i,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*WIDTH-1:0] zahl1_i,
    input  logic [N_REQ*WIDTH-1:0] zahl2_i,
    output logic [N_REQ-1:0]       ack_o,
    output logic [N_REQ-1:0]       done_o,
    output logic [WIDTH-1:0]       ergebnis_o,
    output logic                   err_o,
    output logic                   busy_o,
    output logic                   ggt_rst_o,
    output logic                   ggt_start_o,
    output logic [WIDTH-1:0]       ggt_zahl1_o,
    output logic [WIDTH-1:0]       ggt_zahl2_o,
    input  logic                   ggt_valid_i,
    input  logic [WIDTH-1:0]       ggt_ergebnis_i
);

    localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [ID_W-1:0]  PTR_RST  = ID_W'(N_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FLUSH,
        S_BYPASS,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0]  z1_q, z1_d;
    logic [WIDTH-1:0]  z2_q, z2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  erg_q, erg_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              grst_q, grst_d;
    logic              start_q, start_d;

    logic              win_vld;
    logic [ID_W-1:0]   win_id;
    logic [WIDTH-1:0]  win_z1;
    logic [WIDTH-1:0]  win_z2;

    // Round-robin pick: first active request after the last winner, wrapping.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        win_z1  = '0;
        win_z2  = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            logic [ID_W-1:0] cand;
            cand = ID_W'((32'(ptr_q) + i) % N_REQ);
            if (!win_vld && req_i[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (ID_W'(k) == win_id) begin
                win_z1 = zahl1_i[k*WIDTH +: WIDTH];
                win_z2 = zahl2_i[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and registered-output values for the job sequencer.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        z1_d    = z1_q;
        z2_d    = z2_q;
        cnt_d   = cnt_q;
        erg_d   = erg_q;
        ack_d   = '0;
        done_d  = '0;
        err_d   = 1'b0;
        grst_d  = 1'b0;
        start_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    id_d  = win_id;
                    ptr_d = win_id;
                    z1_d  = win_z1;
                    z2_d  = win_z2;
                    ack_d = N_REQ'(1) << win_id;
                    if ((win_z1 == '0) || (win_z2 == '0)) begin
                        state_d = S_BYPASS;
                        done_d  = N_REQ'(1) << win_id;
                        erg_d   = win_z1 | win_z2;
                    end else begin
                        state_d = S_ISSUE;
                        start_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                // The first WAIT cycle may still show the previous job's valid.
                if (ggt_valid_i && (cnt_q != '0)) begin
                    state_d = S_RESP;
                    erg_d   = ggt_ergebnis_i;
                    done_d  = N_REQ'(1) << id_q;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_FLUSH;
                    grst_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FLUSH: begin
                if (cnt_q == '0) begin
                    grst_d = 1'b1;
                    cnt_d  = CNT_W'(1);
                end else begin
                    state_d = S_RESP;
                    done_d  = N_REQ'(1) << id_q;
                    err_d   = 1'b1;
                    erg_d   = '0;
                end
            end
            S_BYPASS: state_d = S_IDLE;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            id_q    <= '0;
            ptr_q   <= PTR_RST;
            z1_q    <= '0;
            z2_q    <= '0;
            cnt_q   <= '0;
            erg_q   <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            grst_q  <= 1'b1;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            z1_q    <= z1_d;
            z2_q    <= z2_d;
            cnt_q   <= cnt_d;
            erg_q   <= erg_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            grst_q  <= grst_d;
            start_q <= start_d;
        end
    end

    assign ack_o       = ack_q;
    assign done_o      = done_q;
    assign ergebnis_o  = erg_q;
    assign err_o       = err_q;
    assign busy_o      = busy_q;
    assign ggt_rst_o   = grst_q;
    assign ggt_start_o = start_q;
    assign ggt_zahl1_o = z1_q;
    assign ggt_zahl2_o = z2_q;

endmodule

// File: tb/tb_ggt_arbiter.sv
// Bench for ggt_arbiter: table of single jobs, hand sequences, randomized rounds.
module tb_ggt_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int TO = 1024;

    typedef struct {
        logic [N-1:0] mask;
        logic [W-1:0] res;
        logic         err;
        int           cyc;
    } done_t;

    typedef struct {
        logic [N-1:0] mask;
        int           cyc;
    } ack_t;

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           lat;
        logic [W-1:0] exp_res;
        bit           byp;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] z1 = '0;
    logic [N*W-1:0] z2 = '0;
    logic [N-1:0]   ack_o;
    logic [N-1:0]   done_o;
    logic [W-1:0]   ergebnis_o;
    logic           err_o;
    logic           busy_o;
    logic           ggt_rst_o;
    logic           ggt_start_o;
    logic [W-1:0]   ggt_zahl1_o;
    logic [W-1:0]   ggt_zahl2_o;
    logic           ggt_valid;
    logic [W-1:0]   ggt_erg;

    // engine model state
    logic           eng_valid = 1'b0;
    logic [W-1:0]   eng_res = '0;
    int             eng_cnt = 0;
    bit             eng_busy = 1'b0;
    int             eng_lat = 2;
    bit             eng_hang = 1'b0;
    logic           inj_valid = 1'b0;
    logic [W-1:0]   inj_res = '0;

    // bench bookkeeping
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    starts = 0;
    int    start_cyc = 0;
    int    grst_n = 0;
    int    grst_first = -1;
    int    stop_after = 0;
    int    model_ptr = N - 1;
    bit [N-1:0] sticky = '0;
    bit    scramble = 1'b0;
    done_t dq[$];
    ack_t  aq[$];

    always #5 clk = ~clk;

    assign ggt_valid = eng_valid | inj_valid;
    assign ggt_erg   = inj_valid ? inj_res : eng_res;

    ggt_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT_CYC(TO)) dut (
        .clk            (clk),
        .rst_n_i        (rst_n),
        .req_i          (req),
        .zahl1_i        (z1),
        .zahl2_i        (z2),
        .ack_o          (ack_o),
        .done_o         (done_o),
        .ergebnis_o     (ergebnis_o),
        .err_o          (err_o),
        .busy_o         (busy_o),
        .ggt_rst_o      (ggt_rst_o),
        .ggt_start_o    (ggt_start_o),
        .ggt_zahl1_o    (ggt_zahl1_o),
        .ggt_zahl2_o    (ggt_zahl2_o),
        .ggt_valid_i    (ggt_valid),
        .ggt_ergebnis_i (ggt_erg)
    );

    function automatic logic [W-1:0] gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        int x;
        int y;
        int t;
        x = int'(a);
        y = int'(b);
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return W'(x);
    endfunction

    function automatic logic [W-1:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a == '0 || b == '0) return a | b;
        return gcd(a, b);
    endfunction

    function automatic int rr_pick(input int ptr, input logic [N-1:0] m);
        int k;
        for (int i = 1; i <= N; i++) begin
            k = (ptr + i) % N;
            if (m[k]) return k;
        end
        return -1;
    endfunction

    // Engine stand-in: result appears eng_lat+1 cycles after the start edge;
    // a stale valid from the previous job lingers into the first WAIT cycle.
    always @(posedge clk) begin
        if (ggt_rst_o) begin
            eng_busy  <= 1'b0;
            eng_valid <= 1'b0;
        end else if (ggt_start_o) begin
            eng_busy <= 1'b1;
            eng_cnt  <= eng_lat;
        end else if (eng_busy) begin
            if (eng_cnt == 0) begin
                eng_busy  <= 1'b0;
                eng_valid <= !eng_hang;
                if (!eng_hang) eng_res <= gcd(ggt_zahl1_o, ggt_zahl2_o);
            end else begin
                eng_cnt   <= eng_cnt - 1;
                eng_valid <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One cycle: sample outputs at negedge, log events, act as the requesters.
    task automatic step();
        done_t d;
        ack_t  a;
        @(negedge clk);
        cyc++;
        if (ggt_start_o) begin
            starts++;
            start_cyc = cyc;
        end
        if (ggt_rst_o && rst_n) begin
            if (grst_n == 0) grst_first = cyc;
            grst_n++;
        end
        if (ack_o != '0) begin
            a.mask = ack_o;
            a.cyc  = cyc;
            aq.push_back(a);
            for (int k = 0; k < N; k++) begin
                if (ack_o[k] && !sticky[k]) begin
                    req[k] = 1'b0;
                    if (scramble) begin
                        z1[k*W +: W] = W'($urandom);
                        z2[k*W +: W] = W'($urandom);
                    end
                end
            end
        end
        if (done_o != '0) begin
            d.mask = done_o;
            d.res  = ergebnis_o;
            d.err  = err_o;
            d.cyc  = cyc;
            dq.push_back(d);
            if (stop_after > 0 && dq.size() >= stop_after) begin
                req        = '0;
                sticky     = '0;
                stop_after = 0;
            end
        end
    endtask

    task automatic wait_dones(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (dq.size() < n && k < budget) begin
            step();
            k++;
        end
        check({name, "_arrived"}, int'(dq.size() >= n), 1);
    endtask

    task automatic set_ops(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        z1[k*W +: W] = a;
        z2[k*W +: W] = b;
    endtask

    function automatic logic [W-1:0] rand_op();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return '0;
        if (r < 3) return W'($urandom_range(1, 64));
        return W'($urandom_range(1, 65535));
    endfunction

    vec_t vecs[8];
    int   t0;
    int   exp_id[$];
    logic [W-1:0] exp_res[$];

    initial begin
        vecs[0] = '{0, 16'd24255, 16'd12540, 5,    16'd165,   1'b0};
        vecs[1] = '{1, 16'd0,     16'd35,    0,    16'd35,    1'b1};
        vecs[2] = '{2, 16'd0,     16'd0,     0,    16'd0,     1'b1};
        vecs[3] = '{3, 16'd35,    16'd0,     0,    16'd35,    1'b1};
        vecs[4] = '{2, 16'd48,    16'd18,    0,    16'd6,     1'b0};
        vecs[5] = '{1, 16'd81,    16'd27,    TO-2, 16'd27,    1'b0};
        vecs[6] = '{0, 16'd65535, 16'd65535, 2,    16'd65535, 1'b0};
        vecs[7] = '{3, 16'd17,    16'd5,     3,    16'd1,     1'b0};

        // reset values
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_ack",   int'(ack_o), 0);
        check("rst_done",  int'(done_o), 0);
        check("rst_busy",  int'(busy_o), 0);
        check("rst_start", int'(ggt_start_o), 0);
        check("rst_err",   int'(err_o), 0);
        check("rst_erg",   int'(ergebnis_o), 0);
        check("rst_z1",    int'(ggt_zahl1_o), 0);
        check("rst_ggtrst", int'(ggt_rst_o), 1);
        rst_n = 1'b1;
        step();
        check("idle_ggtrst", int'(ggt_rst_o), 0);

        // single-job vectors
        for (int v = 0; v < 8; v++) begin
            dq.delete();
            aq.delete();
            starts = 0;
            set_ops(vecs[v].id, vecs[v].a, vecs[v].b);
            eng_lat = vecs[v].lat;
            req[vecs[v].id] = 1'b1;
            t0 = cyc;
            wait_dones(1, 2000, $sformatf("v%0d", v));
            repeat (3) step();
            check($sformatf("v%0d_ndone", v), dq.size(), 1);
            if (dq.size() >= 1) begin
                check($sformatf("v%0d_mask", v), int'(dq[0].mask), 1 << vecs[v].id);
                check($sformatf("v%0d_res", v), int'(dq[0].res), int'(vecs[v].exp_res));
                check($sformatf("v%0d_err", v), int'(dq[0].err), 0);
                check($sformatf("v%0d_cyc", v), dq[0].cyc,
                      vecs[v].byp ? t0 + 1 : t0 + 4 + vecs[v].lat);
            end
            check($sformatf("v%0d_nack", v), aq.size(), 1);
            if (aq.size() >= 1) begin
                check($sformatf("v%0d_ackmask", v), int'(aq[0].mask), 1 << vecs[v].id);
                check($sformatf("v%0d_ackcyc", v), aq[0].cyc, t0 + 1);
            end
            check($sformatf("v%0d_starts", v), starts, vecs[v].byp ? 0 : 1);
            model_ptr = vecs[v].id;
        end

        // all four at once, twice
        set_ops(0, 16'd48, 16'd18);
        set_ops(1, 16'd35, 16'd14);
        set_ops(2, 16'd81, 16'd27);
        set_ops(3, 16'd17, 16'd5);
        eng_lat = 2;
        for (int rep = 0; rep < 2; rep++) begin
            dq.delete();
            aq.delete();
            req = 4'b1111;
            wait_dones(4, 400, $sformatf("all4_r%0d", rep));
            repeat (3) step();
            check($sformatf("all4_r%0d_n", rep), dq.size(), 4);
            exp_res = '{16'd6, 16'd7, 16'd27, 16'd1};
            for (int i = 0; i < 4 && i < dq.size(); i++) begin
                check($sformatf("all4_r%0d_id%0d", rep, i), int'(dq[i].mask), 1 << i);
                check($sformatf("all4_r%0d_res%0d", rep, i), int'(dq[i].res), int'(exp_res[i]));
                if (i > 0 && i < aq.size())
                    check($sformatf("all4_r%0d_gap%0d", rep, i), aq[i].cyc, dq[i-1].cyc + 2);
            end
        end
        model_ptr = 3;

        // requesters 1 and 2 held high: grants alternate
        dq.delete();
        sticky = 4'b0110;
        stop_after = 4;
        req = 4'b0110;
        wait_dones(4, 400, "alt");
        repeat (5) step();
        check("alt_n", dq.size(), 4);
        for (int i = 0; i < 4 && i < dq.size(); i++)
            check($sformatf("alt_id%0d", i), int'(dq[i].mask), (i % 2 == 0) ? 2 : 4);
        model_ptr = 2;

        // hung engine -> timeout, flush, error response
        dq.delete();
        starts = 0;
        grst_n = 0;
        grst_first = -1;
        eng_hang = 1'b1;
        eng_lat = TO + 50;
        set_ops(0, 16'd48, 16'd18);
        req[0] = 1'b1;
        t0 = cyc;
        repeat (4) step();
        check("to_busy", int'(busy_o), 1);
        check("to_startcyc", start_cyc, t0 + 1);
        wait_dones(1, TO + 100, "to");
        repeat (3) step();
        check("to_grst_n", grst_n, 2);
        check("to_grst_first", grst_first, start_cyc + TO + 1);
        if (dq.size() >= 1) begin
            check("to_mask", int'(dq[0].mask), 1);
            check("to_err", int'(dq[0].err), 1);
            check("to_res", int'(dq[0].res), 0);
            check("to_cyc", dq[0].cyc, start_cyc + TO + 3);
        end
        check("to_idle_busy", int'(busy_o), 0);
        eng_hang = 1'b0;
        eng_lat = 2;
        dq.delete();
        req[0] = 1'b1;
        wait_dones(1, 200, "after_to");
        step();
        if (dq.size() >= 1) begin
            check("after_to_res", int'(dq[0].res), 6);
            check("after_to_err", int'(dq[0].err), 0);
        end
        model_ptr = 0;

        // reset during WAIT drops the job
        dq.delete();
        eng_lat = 20;
        set_ops(2, 16'd81, 16'd27);
        req = 4'b0100;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        check("mid_rst_ack",   int'(ack_o), 0);
        check("mid_rst_done",  int'(done_o), 0);
        check("mid_rst_busy",  int'(busy_o), 0);
        check("mid_rst_start", int'(ggt_start_o), 0);
        check("mid_rst_err",   int'(err_o), 0);
        check("mid_rst_erg",   int'(ergebnis_o), 0);
        check("mid_rst_z1",    int'(ggt_zahl1_o), 0);
        check("mid_rst_z2",    int'(ggt_zahl2_o), 0);
        check("mid_rst_grst",  int'(ggt_rst_o), 1);
        rst_n = 1'b1;
        inj_res = 16'h1234;
        inj_valid = 1'b1;
        repeat (2) step();
        inj_valid = 1'b0;
        repeat (10) step();
        check("mid_rst_nodone", dq.size(), 0);
        set_ops(1, 16'd48, 16'd18);
        set_ops(3, 16'd35, 16'd14);
        eng_lat = 2;
        req = 4'b1010;
        wait_dones(2, 300, "post_rst");
        repeat (2) step();
        if (dq.size() >= 2) begin
            check("post_rst_id0", int'(dq[0].mask), 2);
            check("post_rst_res0", int'(dq[0].res), 6);
            check("post_rst_id1", int'(dq[1].mask), 8);
            check("post_rst_res1", int'(dq[1].res), 7);
        end
        model_ptr = 3;

        // randomized rounds against the reference model
        scramble = 1'b1;
        for (int r = 0; r < 40; r++) begin
            logic [N-1:0] m;
            logic [N-1:0] left;
            int pick;
            m = N'($urandom_range(1, (1 << N) - 1));
            exp_id.delete();
            exp_res.delete();
            for (int k = 0; k < N; k++) if (m[k]) set_ops(k, rand_op(), rand_op());
            left = m;
            while (left != '0) begin
                pick = rr_pick(model_ptr, left);
                exp_id.push_back(pick);
                exp_res.push_back(ref_result(z1[pick*W +: W], z2[pick*W +: W]));
                model_ptr = pick;
                left[pick] = 1'b0;
            end
            eng_lat = $urandom_range(0, 10);
            dq.delete();
            req = m;
            wait_dones(exp_id.size(), 200, $sformatf("rnd%0d", r));
            repeat (2) step();
            check($sformatf("rnd%0d_n", r), dq.size(), exp_id.size());
            for (int i = 0; i < exp_id.size() && i < dq.size(); i++) begin
                check($sformatf("rnd%0d_id%0d", r, i), int'(dq[i].mask), 1 << exp_id[i]);
                check($sformatf("rnd%0d_res%0d", r, i), int'(dq[i].res), int'(exp_res[i]));
                check($sformatf("rnd%0d_err%0d", r, i), int'(dq[i].err), 0);
            end
        end
        scramble = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
